// File: rtl/line_memory_responder.sv
// Fixed-latency backing store for 256-bit cache lines: accepts one line read or
// write at a time and completes it with a single-cycle ack after LATENCY cycles.
module line_memory_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [7:0] LOAD = 8'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             r_state;
    logic [7:0]         r_count;
    logic [IDX_W-1:0]   r_idx;
    logic               r_write;
    logic [255:0]       r_wdata;
    logic               r_ack;
    logic               r_busy;
    logic [255:0]       r_rdata;

    logic [255:0]       memory [DEPTH];

    logic               w_done;
    logic               w_commit;
    logic               w_unused_addr;

    assign w_done        = (r_state == BUSY) && (r_count == 8'd0);
    assign w_commit      = w_done && r_write;
    assign w_unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

    assign ack_o  = r_ack;
    assign busy_o = r_busy;
    assign data_o = r_rdata;

    // Request capture, latency countdown and registered completion. Anything
    // presented on the inputs while BUSY is ignored; only the captured copies count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_count <= 8'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                    if (enable_i) begin
                        r_idx   <= addr_i[IDX_W+4:5];
                        r_write <= write_i;
                        r_wdata <= data_i;
                        r_count <= LOAD;
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_count == 8'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b1;
                        r_rdata <= r_write ? '0 : memory[r_idx];
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The array has no reset; a write aborted by reset never reaches it because
    // reset forces the state back to IDLE before the completion edge.
    always @(posedge clk_i) begin
        if (w_commit) begin
            memory[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed self-checking bench for line_memory_responder (DEPTH=512, LATENCY=10).
module tb_line_memory_responder;

    localparam int DEPTH = 512;
    localparam int LAT   = 10;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_DB = {8{32'hDEADBEEF}};
    localparam logic [255:0] PAT_L5 = {8{32'h5555_0005}};
    localparam logic [255:0] PAT_L6 = {8{32'h6666_0006}};
    localparam logic [255:0] PAT_L7 = {8{32'h7777_0007}};
    localparam logic [255:0] PAT_NW = {8{32'hBAD0_BAD0}};
    localparam logic [255:0] PAT_L0 = {8{32'h0123_4567}};

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    line_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Issues one request from the current negedge and samples until its ack.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [255:0] wdata,
                           output int busyCnt, output int ackAt, output logic [255:0] rdata,
                           output int overlap);
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = addr;
        data_i   = wdata;
        busyCnt  = 0;
        ackAt    = -1;
        rdata    = '0;
        overlap  = 0;
        for (int k = 1; k <= LAT + 5; k++) begin
            @(negedge clk_i);
            if (busy_o) busyCnt++;
            if (busy_o && ack_o) overlap++;
            if (ack_o) begin
                ackAt = k;
                rdata = data_o;
                break;
            end
        end
        enable_i = 1'b0;
        write_i  = 1'b0;
    endtask

    task automatic test_reset();
        int b, a, o;
        logic [255:0] r;
        rst_i    = 1'b0;
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 32'h60;
        data_i   = '0;
        dut.memory[3] = PAT_A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if ({ack_o, busy_o, data_o} !== 258'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs ack=%b busy=%b data=%h required all zero", ack_o, busy_o, data_o);
            end
        end
        rst_i = 1'b1;
        run_txn(1'b0, 32'h60, '0, b, a, r, o);
        checks++;
        if (a !== LAT + 1) begin
            errors++;
            $display("[TB] FAIL reset_first_ack ack_at=%0d required %0d", a, LAT + 1);
        end
        checks++;
        if (r !== PAT_A5) begin
            errors++;
            $display("[TB] FAIL reset_first_data got %h required %h", r, PAT_A5);
        end
        @(negedge clk_i);
    endtask

    task automatic test_idle();
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if ({ack_o, busy_o, data_o} !== 258'd0) begin
                errors++;
                $display("[TB] FAIL idle_outputs ack=%b busy=%b data=%h required all zero", ack_o, busy_o, data_o);
            end
        end
    endtask

    task automatic test_read();
        int b, a, o;
        logic [255:0] r;
        run_txn(1'b0, 32'h60, '0, b, a, r, o);
        checks++;
        if (b !== LAT) begin
            errors++;
            $display("[TB] FAIL read_busy_cycles got %0d required %0d", b, LAT);
        end
        checks++;
        if (a !== LAT + 1) begin
            errors++;
            $display("[TB] FAIL read_ack_at got %0d required %0d", a, LAT + 1);
        end
        checks++;
        if (r !== PAT_A5) begin
            errors++;
            $display("[TB] FAIL read_data got %h required %h", r, PAT_A5);
        end
        checks++;
        if (o !== 0) begin
            errors++;
            $display("[TB] FAIL read_busy_ack_overlap got %0d required 0", o);
        end
        @(negedge clk_i);
        checks++;
        if ({ack_o, data_o} !== 257'd0) begin
            errors++;
            $display("[TB] FAIL read_after_ack ack=%b data=%h required zero", ack_o, data_o);
        end
    endtask

    task automatic test_back_to_back();
        int b, a, o;
        logic [255:0] r;
        run_txn(1'b1, 32'h80, PAT_DB, b, a, r, o);
        checks++;
        if (a !== LAT + 1) begin
            errors++;
            $display("[TB] FAIL b2b_write_ack_at got %0d required %0d", a, LAT + 1);
        end
        checks++;
        if (r !== '0) begin
            errors++;
            $display("[TB] FAIL b2b_write_data_o got %h required 0", r);
        end
        run_txn(1'b0, 32'h9F, '0, b, a, r, o);
        checks++;
        if (b !== LAT) begin
            errors++;
            $display("[TB] FAIL b2b_read_busy got %0d required %0d", b, LAT);
        end
        checks++;
        if (a !== LAT + 1) begin
            errors++;
            $display("[TB] FAIL b2b_read_ack_at got %0d required %0d", a, LAT + 1);
        end
        checks++;
        if (r !== PAT_DB) begin
            errors++;
            $display("[TB] FAIL b2b_read_data got %h required %h", r, PAT_DB);
        end
        @(negedge clk_i);
    endtask

    task automatic test_input_ignore();
        int b, a, o;
        logic [255:0] r;
        dut.memory[5] = PAT_L5;
        dut.memory[6] = PAT_L6;
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 32'hA0;
        data_i   = '0;
        a = -1;
        r = '0;
        for (int k = 1; k <= LAT + 5; k++) begin
            @(negedge clk_i);
            if (ack_o) begin
                a = k;
                r = data_o;
                break;
            end
            addr_i  = 32'hC0 | 32'(k & 31);
            write_i = 1'b1;
            data_i  = {8{$urandom}};
        end
        enable_i = 1'b0;
        write_i  = 1'b0;
        checks++;
        if (a !== LAT + 1) begin
            errors++;
            $display("[TB] FAIL ignore_ack_at got %0d required %0d", a, LAT + 1);
        end
        checks++;
        if (r !== PAT_L5) begin
            errors++;
            $display("[TB] FAIL ignore_read_data got %h required %h", r, PAT_L5);
        end
        @(negedge clk_i);
        run_txn(1'b0, 32'hC0, '0, b, a, r, o);
        checks++;
        if (r !== PAT_L6) begin
            errors++;
            $display("[TB] FAIL ignore_line6_intact got %h required %h", r, PAT_L6);
        end
        @(negedge clk_i);
        run_txn(1'b0, 32'hA0, '0, b, a, r, o);
        checks++;
        if (r !== PAT_L5) begin
            errors++;
            $display("[TB] FAIL ignore_line5_intact got %h required %h", r, PAT_L5);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_abort();
        int b, a, o, acks;
        logic [255:0] r;
        dut.memory[7] = PAT_L7;
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'hE0;
        data_i   = PAT_NW;
        repeat (4) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_busy_before got %b required 1", busy_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, ack_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL abort_outputs busy=%b ack=%b required 0 0", busy_o, ack_o);
        end
        enable_i = 1'b0;
        write_i  = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        acks = 0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk_i);
            if (ack_o) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_ack got %0d acks required 0", acks);
        end
        run_txn(1'b0, 32'hE0, '0, b, a, r, o);
        checks++;
        if (r !== PAT_L7) begin
            errors++;
            $display("[TB] FAIL abort_line7_kept got %h required %h", r, PAT_L7);
        end
        @(negedge clk_i);
    endtask

    task automatic test_wrap();
        int b, a, o;
        logic [255:0] r;
        dut.memory[0] = PAT_L0;
        run_txn(1'b0, 32'h4000, '0, b, a, r, o);
        checks++;
        if (r !== PAT_L0) begin
            errors++;
            $display("[TB] FAIL wrap_read got %h required %h", r, PAT_L0);
        end
        @(negedge clk_i);
    endtask

    task automatic test_continuous();
        int acks, first, last, overlap, badData;
        acks = 0; first = -1; last = -1; overlap = 0; badData = 0;
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 32'h60;
        data_i   = '0;
        for (int k = 1; k <= 4 * (LAT + 1) + 2; k++) begin
            @(negedge clk_i);
            if (busy_o && ack_o) overlap++;
            if (ack_o) begin
                acks++;
                if (first < 0) first = k;
                last = k;
                if (data_o !== PAT_A5) badData++;
            end
        end
        enable_i = 1'b0;
        checks++;
        if (acks !== 4) begin
            errors++;
            $display("[TB] FAIL cont_ack_count got %0d required 4", acks);
        end
        checks++;
        if (first !== LAT + 1) begin
            errors++;
            $display("[TB] FAIL cont_first_ack got %0d required %0d", first, LAT + 1);
        end
        checks++;
        if (last - first !== 3 * (LAT + 1)) begin
            errors++;
            $display("[TB] FAIL cont_spacing got %0d required %0d", last - first, 3 * (LAT + 1));
        end
        checks++;
        if (overlap !== 0 || badData !== 0) begin
            errors++;
            $display("[TB] FAIL cont_overlap_data overlap=%0d bad=%0d required 0 0", overlap, badData);
        end
        repeat (LAT + 3) @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_read();
        test_back_to_back();
        test_input_ignore();
        test_reset_abort();
        test_wrap();
        test_continuous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
